// File: rtl/stream_mux_rr_if.sv
// rtl/stream_mux_rr_if.sv - producer/consumer handshake bundle for stream_mux_rr (in_last only with STREAM_MUX_RR_LOCK_EN)
interface stream_mux_rr_if #(
  parameter int N = 4,
  parameter int W = 8
) ();
  localparam int SW = $clog2(N);

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
`ifdef STREAM_MUX_RR_LOCK_EN
  logic [N-1:0]   in_last;
`endif
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  modport master (
    output in_valid, in_data,
`ifdef STREAM_MUX_RR_LOCK_EN
    output in_last,
`endif
    output out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data,
`ifdef STREAM_MUX_RR_LOCK_EN
    input  in_last,
`endif
    input  out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-input round-robin stream mux with one registered output stage
// Packet locking on in_last is built only when STREAM_MUX_RR_LOCK_EN is defined.
module stream_mux_rr #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  stream_mux_rr_if.slave bus
);
  localparam int SW = $clog2(N);

  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [W-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic [SW-1:0] grant;
  logic          req;
  logic          load;
  logic          accept;
  logic [N-1:0]  ready;

`ifdef STREAM_MUX_RR_LOCK_EN
  typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_e;
  lock_state_e   state_q, state_d;
  logic [SW-1:0] lock_ch_q, lock_ch_d;
`endif

  function automatic logic [SW-1:0] next_ch(input logic [SW-1:0] ch);
    return (ch == SW'(N - 1)) ? '0 : ch + SW'(1);
  endfunction

  // Scan from the farthest slot back to ptr so the nearest requester is written last.
  always_comb begin
    int idx;
    idx   = 0;
    grant = ptr_q;
    req   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (bus.in_valid[idx]) begin
        grant = SW'(idx);
        req   = 1'b1;
      end
    end
`ifdef STREAM_MUX_RR_LOCK_EN
    if (state_q == ST_LOCKED) begin
      grant = lock_ch_q;
      req   = bus.in_valid[lock_ch_q];
    end
`endif
  end

  assign load   = !valid_q || bus.out_ready;
  assign accept = !rst && load && req;

  always_comb begin
    ready = '0;
    if (accept) ready[grant] = 1'b1;
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef STREAM_MUX_RR_LOCK_EN
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
`endif
    if (accept) begin
      valid_d = 1'b1;
      data_d  = bus.in_data[int'(grant)*W +: W];
      sel_d   = grant;
`ifdef STREAM_MUX_RR_LOCK_EN
      // ptr stays put for the whole packet and only moves past g on its last beat.
      if (!bus.in_last[grant]) begin
        state_d   = ST_LOCKED;
        lock_ch_d = grant;
      end else begin
        state_d = ST_OPEN;
        ptr_d   = next_ch(grant);
      end
`else
      ptr_d = next_ch(grant);
`endif
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
`ifdef STREAM_MUX_RR_LOCK_EN
      state_q   <= ST_OPEN;
      lock_ch_q <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
`ifdef STREAM_MUX_RR_LOCK_EN
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
`endif
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - randomized and directed bench for stream_mux_rr against a behavioural model
module tb_stream_mux_rr;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural model: state as it will be right after the next rising edge.
  int           m_ptr = 0;
  int           m_sel = 0;
  int           m_lock_ch = 0;
  logic         m_valid = 1'b0;
  logic         m_locked = 1'b0;
  logic [W-1:0] m_data = '0;

  always #5 clk = ~clk;

  stream_mux_rr_if #(.N(N), .W(W)) bus ();

  stream_mux_rr #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_req(input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [W-1:0] val);
    bus.in_data[ch*W +: W] = val;
  endtask

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  initial begin
    logic         load;
    logic         last;
    int           g;
    logic [N-1:0] exp_ready;
    @(posedge clk);
    forever begin
      @(negedge clk);
      load = !m_valid || bus.out_ready;
      if (m_locked) g = bus.in_valid[m_lock_ch] ? m_lock_ch : -1;
      else          g = first_req(m_ptr, bus.in_valid);
      exp_ready = '0;
      if (!rst && load && g >= 0) exp_ready[g] = 1'b1;
      check("model_in_ready", 32'(bus.in_ready), 32'(exp_ready));
      check("model_out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("model_out_data", 32'(bus.out_data), 32'(m_data));
      check("model_out_sel", 32'(bus.out_sel), 32'(m_sel));
      if (rst) begin
        m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0; m_locked = 1'b0; m_lock_ch = 0;
      end else if (exp_ready != '0) begin
        m_valid = 1'b1;
        m_data  = bus.in_data[g*W +: W];
        m_sel   = g;
        last    = 1'b1;
`ifdef STREAM_MUX_RR_LOCK_EN
        last = bus.in_last[g];
`endif
        if (!last) begin
          m_locked  = 1'b1;
          m_lock_ch = g;
        end else begin
          m_locked = 1'b0;
          m_ptr    = (g + 1) % N;
        end
      end else if (bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef STREAM_MUX_RR_LOCK_EN
    bus.in_last = '1;
`endif
    step();
    step();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) step();
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    check("idle_out_data", 32'(bus.out_data), 32'd0);
    check("idle_out_sel", 32'(bus.out_sel), 32'd0);
    check("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // All channels requesting: strict rotation, one beat per cycle
    for (int i = 0; i < N; i++) set_data(i, 8'hA0 + 8'(i));
    bus.in_valid  = '1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_out_valid", 32'(bus.out_valid), 32'd1);
      check("rr_out_sel", 32'(bus.out_sel), 32'(k % 4));
      check("rr_out_data", 32'(bus.out_data), 32'(8'hA0 + 8'(k % 4)));
    end
    bus.in_valid = '0;
    step();

    // Channels 1 and 3 with a stalled consumer
    set_data(1, 8'h11);
    set_data(3, 8'h33);
    bus.in_valid  = 4'b1010;
    bus.out_ready = 1'b0;
    step();
    check("stall_first_sel", 32'(bus.out_sel), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      step();
      check("stall_data_hold", 32'(bus.out_data), 32'h11);
      check("stall_sel_hold", 32'(bus.out_sel), 32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("drain_in_ready", 32'(bus.in_ready), 32'b1000);
    step();
    check("stall_second_sel", 32'(bus.out_sel), 32'd3);
    check("stall_second_data", 32'(bus.out_data), 32'h33);
    bus.in_valid = '0;
    step();
    check("drained_out_valid", 32'(bus.out_valid), 32'd0);

    // Wrap-around: grant 2 leaves ptr at 3, then only channel 0 requests
    bus.in_valid = 4'b0100;
    step();
    check("wrap_pre_sel", 32'(bus.out_sel), 32'd2);
    bus.in_valid = 4'b0001;
    step();
    check("wrap_sel", 32'(bus.out_sel), 32'd0);
    bus.in_valid = 4'b1111;
    step();
    check("wrap_ptr_next", 32'(bus.out_sel), 32'd1);

    // Reset while holding a beat with every channel requesting
    bus.out_ready = 1'b0;
    step();
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sel", 32'(bus.out_sel), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("post_rst_sel", 32'(bus.out_sel), 32'd0);

`ifdef STREAM_MUX_RR_LOCK_EN
    // ptr is 1: channel 2's three-beat packet must not be interleaved with channel 0
    bus.in_valid = 4'b0101;
    set_data(0, 8'hB0);
    for (int b = 0; b < 3; b++) begin
      set_data(2, 8'hC0 + 8'(b));
      bus.in_last[2] = (b == 2);
      step();
      check("lock_sel", 32'(bus.out_sel), 32'd2);
      check("lock_data", 32'(bus.out_data), 32'(8'hC0 + 8'(b)));
    end
    bus.in_valid = 4'b0001;
    step();
    check("lock_release_sel", 32'(bus.out_sel), 32'd0);
    bus.in_last = '1;
`endif

    // Randomized traffic with occasional reset
    for (int c = 0; c < 2000; c++) begin
      rst           = ($urandom_range(0, 63) == 0);
      bus.in_valid  = N'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) set_data(i, W'($urandom));
`ifdef STREAM_MUX_RR_LOCK_EN
      bus.in_last = N'($urandom) | N'($urandom);
`endif
      step();
    end
    rst = 1'b0;
    bus.in_valid = '0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-input, W-bit streaming multiplexer with round-robin arbitration and valid/ready handshakes on every port. It generalises the four-input select mux: instead of an external select, it chooses among requesting channels fairly and registers the result into a single output stage. It sits between several producer streams and one shared consumer, for example a bus or serializer.

## Interface
- N, 4, number of input channels; legal range 2..16.
- W, 8, data width in bits per channel.
- SW, derived as $clog2(N), width of the channel index; not overridable.
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  N  bit i set means channel i presents a beat.
- in_data  in  N*W  channel i's data is in_data[i*W +: W].
- in_ready  out  N  one-hot or zero; bit i set means channel i's beat is taken this cycle. Combinational.
- out_valid  out  1  the output register holds a beat.
- out_data  out  W  data of the held beat.
- out_sel  out  SW  index of the channel that supplied the held beat.
- out_ready  in  1  the consumer accepts the held beat this cycle.
- in_last  in  N  present only when STREAM_MUX_RR_LOCK_EN is defined. Bit i marks the last beat of channel i's packet.

## Operation
- A beat transfers on any port when valid and ready are both high at a rising edge.
- load = !out_valid || out_ready.
  - Output stage accepts a new beat while empty, or in the same cycle the held beat drains.
  - Sustains one beat per cycle.
- Round-robin pointer ptr, SW bits, reset 0.
  - grant = first i with in_valid[i] set, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap at N).
- in_ready[i] = load && any in_valid && (grant == i).
  - At most one bit is set.
  - in_ready never depends on in_data.
- On accept from channel g:
  - out_data <= that channel's data, out_sel <= g, out_valid <= 1.
  - ptr <= (g+1) mod N, wrapping from N-1 to 0.
- Held beat drains with no new accept: out_valid <= 0; out_data and out_sel keep their values.
- No requests: ptr holds and in_ready = 0.
- A producer may drop in_valid before it is granted; the beat is then never transferred. Not an error.
- out_data and out_sel stay stable while out_valid && !out_ready.

## Timing
- Latency: a beat accepted at edge k is visible at out_* right after edge k. The consumer can take it at edge k+1 at the earliest.
- Throughput: 1 beat per cycle with out_ready held high.
- Fairness: with all N channels requesting continuously, each channel is granted exactly once in every N consecutive accepts.
- Reset (rst high at an edge) takes priority over all other events:
  - out_valid=0, out_data=0, out_sel=0, ptr=0, lock cleared.
  - in_ready=0 during any cycle rst is high.
  - Reset mid-stream drops the held beat without signalling it.
- Simultaneous drain and accept in one cycle: the new beat replaces the old one; no bubble cycle.

## Configuration
- STREAM_MUX_RR_LOCK_EN defined:
  - The in_last port exists.
  - When channel g's beat is accepted with in_last[g]=0, a lock is set and grant is forced to g.
  - While locked, other channels get in_ready=0 even if g is idle.
  - The lock clears and ptr advances to (g+1) mod N only when g's beat with in_last[g]=1 is accepted.
  - Single-beat packets behave exactly as without the macro.
- Not defined: no in_last port, no lock logic. Arbitration runs on every beat.

## Test plan
- Reset, then all inputs idle for 5 cycles -> out_valid=0, out_data=0, out_sel=0, in_ready=0.
- N=4, W=8, all channels valid (data 8'hA0..8'hA3), out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3; out_data follows it; one beat per cycle.
- Channels 1 and 3 valid, out_ready=0 for 3 cycles, then 1 -> channel 1 is taken first, out_data stays stable while stalled, in_ready=0 while stalled, then channel 3's beat follows.
- Wrap-around: ptr=3 after a channel-2 grant, only channel 0 valid -> channel 0 granted, ptr becomes 1.
- rst asserted while out_valid=1 and every channel is requesting -> next cycle out_valid=0, ptr=0; first grant after release is channel 0.
- With STREAM_MUX_RR_LOCK_EN, channel 2 sends 3 beats (in_last=0,0,1) while channel 0 is requesting -> all 3 channel-2 beats are output consecutively, then channel 0 is granted.
